// File: rtl/stoplight_ctrl.sv
// Multi-direction traffic-light controller: green/yellow/all-red rotation with
// empty-direction skipping and a latched pedestrian walk phase.
module stoplight_ctrl #(
    parameter int unsigned NUM_DIR    = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GREEN_CYC  = 20,
    parameter int unsigned YELLOW_CYC = 5,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned WALK_CYC   = 10,
    parameter int unsigned SKIP_EMPTY = 1,
    localparam int unsigned DIR_W     = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    input  logic               ped_req,
    input  logic [NUM_DIR-1:0] sensor,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic               walk,
    output logic               ped_pending,
    output logic [DIR_W-1:0]   active_dir
);

    localparam int unsigned IW = DIR_W + 1;
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);
    localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIR - 1);

    typedef enum logic [1:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW,
        S_WALK
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic               pend_q, pend_d;
    logic               grant;
    logic [DIR_W-1:0]   nxt_dir;
    logic [NUM_DIR-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
    logic               walk_q, walk_d;

    // Round-robin search starting one past the current direction; with no
    // sensor set (or skipping disabled) it falls back to the plain successor.
    always_comb begin : sel_dir
        logic [IW-1:0] idx;
        logic          found;
        nxt_dir = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
        found   = 1'b0;
        idx     = '0;
        if (SKIP_EMPTY != 0) begin
            for (int unsigned k = 1; k <= NUM_DIR; k++) begin
                idx = {1'b0, dir_q} + IW'(k);
                if (idx >= IW'(NUM_DIR)) idx = idx - IW'(NUM_DIR);
                if (!found && sensor[idx[DIR_W-1:0]]) begin
                    nxt_dir = idx[DIR_W-1:0];
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        grant   = 1'b0;
        if (en) begin
            if (timer_q != '0) begin
                timer_d = timer_q - CNT_W'(1);
            end else begin
                unique case (state_q)
                    S_ALLRED: begin
                        if (pend_q) begin
                            state_d = S_WALK;
                            timer_d = WALK_LD;
                            grant   = 1'b1;
                        end else begin
                            state_d = S_GREEN;
                            timer_d = GREEN_LD;
                            dir_d   = nxt_dir;
                        end
                    end
                    S_GREEN: begin
                        state_d = S_YELLOW;
                        timer_d = YELLOW_LD;
                    end
                    S_YELLOW, S_WALK: begin
                        state_d = S_ALLRED;
                        timer_d = ALLRED_LD;
                    end
                    default: begin
                        state_d = S_ALLRED;
                        timer_d = ALLRED_LD;
                    end
                endcase
            end
        end
        // A request coinciding with the grant is served by that same walk.
        pend_d = grant ? 1'b0 : (pend_q | ped_req);

        // Lamps are decoded from next state so they register alongside it.
        green_d  = '0;
        yellow_d = '0;
        for (int unsigned i = 0; i < NUM_DIR; i++) begin
            green_d[i]  = (state_d == S_GREEN)  && (dir_d == DIR_W'(i));
            yellow_d[i] = (state_d == S_YELLOW) && (dir_d == DIR_W'(i));
        end
        red_d  = ~(green_d | yellow_d);
        walk_d = (state_d == S_WALK);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_ALLRED;
            timer_q  <= ALLRED_LD;
            dir_q    <= LAST_DIR;
            pend_q   <= 1'b0;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
            walk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
            walk_q   <= walk_d;
        end
    end

    assign red         = red_q;
    assign yellow      = yellow_q;
    assign green       = green_q;
    assign walk        = walk_q;
    assign ped_pending = pend_q;
    assign active_dir  = dir_q;

endmodule

// File: tb/tb_stoplight_ctrl.sv
// Scoreboard bench for stoplight_ctrl: a skipping and a fixed-rotation
// instance share stimulus and are compared against an elapsed-count model.
module tb_stoplight_ctrl;

    logic       clk, nrst, en, ped_req;
    logic [2:0] sensor;
    logic [2:0] red_a, yellow_a, green_a, red_b, yellow_b, green_b;
    logic       walk_a, pend_a, walk_b, pend_b;
    logic [1:0] dir_a, dir_b;
    logic [12:0] act_a, act_b;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];

    int m_st[2], m_el[2], m_dir[2];
    bit m_pend[2];

    localparam logic [12:0] RST_VEC = {3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2};

    stoplight_ctrl #(.NUM_DIR(3), .CNT_W(8), .GREEN_CYC(4), .YELLOW_CYC(2),
                     .ALLRED_CYC(1), .WALK_CYC(3), .SKIP_EMPTY(1)) dut_a (
        .clk(clk), .nrst(nrst), .en(en), .ped_req(ped_req), .sensor(sensor),
        .red(red_a), .yellow(yellow_a), .green(green_a), .walk(walk_a),
        .ped_pending(pend_a), .active_dir(dir_a));

    stoplight_ctrl #(.NUM_DIR(3), .CNT_W(8), .GREEN_CYC(4), .YELLOW_CYC(2),
                     .ALLRED_CYC(1), .WALK_CYC(3), .SKIP_EMPTY(0)) dut_b (
        .clk(clk), .nrst(nrst), .en(en), .ped_req(ped_req), .sensor(sensor),
        .red(red_b), .yellow(yellow_b), .green(green_b), .walk(walk_b),
        .ped_pending(pend_b), .active_dir(dir_b));

    assign act_a = {red_a, yellow_a, green_a, walk_a, pend_a, dir_a};
    assign act_b = {red_b, yellow_b, green_b, walk_b, pend_b, dir_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dur(input int s);
        case (s)
            0: return 1;
            1: return 4;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_el[i] = 0; m_dir[i] = 2; m_pend[i] = 0;
        end
    endtask

    function automatic int pick(input int i, input logic [2:0] s);
        int nd;
        nd = (m_dir[i] + 1) % 3;
        if (i == 0 && !s[nd]) begin
            for (int k = 2; k <= 3; k++)
                if (s[(m_dir[i] + k) % 3]) return (m_dir[i] + k) % 3;
        end
        return nd;
    endfunction

    task automatic model_step(input int i, input bit e, input bit p, input logic [2:0] s);
        bit g;
        g = 0;
        if (e) begin
            if (m_el[i] < dur(m_st[i]) - 1) m_el[i]++;
            else begin
                m_el[i] = 0;
                case (m_st[i])
                    0: if (m_pend[i]) begin m_st[i] = 3; g = 1; end
                       else begin m_dir[i] = pick(i, s); m_st[i] = 1; end
                    1: m_st[i] = 2;
                    default: m_st[i] = 0;
                endcase
            end
        end
        m_pend[i] = g ? 1'b0 : (m_pend[i] | p);
    endtask

    function automatic logic [12:0] m_out(input int i);
        logic [2:0] g, y;
        g = (m_st[i] == 1) ? 3'(1 << m_dir[i]) : 3'b000;
        y = (m_st[i] == 2) ? 3'(1 << m_dir[i]) : 3'b000;
        return {~(g | y), y, g, (m_st[i] == 3), m_pend[i], 2'(m_dir[i])};
    endfunction

    function automatic logic inv_ok(input logic [2:0] r, y, g, input logic w);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < 3; d++)
            if ((32'(r[d]) + 32'(y[d]) + 32'(g[d])) != 1) ok = 1'b0;
        if ($countones(~r) > 1) ok = 1'b0;
        if (w && r != 3'b111) ok = 1'b0;
        return ok;
    endfunction

    task automatic tick(input bit e, input bit p, input logic [2:0] s);
        en = e; ped_req = p; sensor = s;
        for (int i = 0; i < 2; i++) begin
            model_step(i, e, p, s);
            exp_q.push_back(m_out(i));
        end
        @(posedge clk);
        #1;
        check("out_a", act_a, exp_q.pop_front());
        check("out_b", act_b, exp_q.pop_front());
        check("inv_a", inv_ok(red_a, yellow_a, green_a, walk_a), 1);
        check("inv_b", inv_ok(red_b, yellow_b, green_b, walk_b), 1);
        @(negedge clk);
        ped_req = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        nrst = 1'b0;
        #1;
        check("rst_a", act_a, RST_VEC);
        check("rst_b", act_b, RST_VEC);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        int walk_cnt;
        nrst = 1'b0; en = 1'b0; ped_req = 1'b0; sensor = 3'b000;
        model_reset();
        repeat (2) @(negedge clk);
        check("por_a", act_a, RST_VEC);
        nrst = 1'b1;

        // Reset mid-green, then rotation and pedestrian walk
        tick(1, 0, 3'b111);
        tick(1, 0, 3'b111);
        check("pre_rst_g", green_a, 3'b001);
        do_reset();
        for (int n = 1; n <= 33; n++) begin
            tick(1, n == 23, 3'b111);
            case (n)
                1, 4, 22: check("rot_g0", green_a, 3'b001);
                5, 6:     check("rot_y0", yellow_a, 3'b001);
                7:        check("rot_ar", red_a, 3'b111);
                8:        check("rot_g1", green_a, 3'b010);
                15:       check("rot_g2", green_a, 3'b100);
                23:       check("ped_set", pend_a, 1'b1);
                28:       check("ped_ar", {red_a, walk_a, pend_a}, 5'b11101);
                29:       check("walk_in", {walk_a, pend_a}, 2'b10);
                31:       check("walk_end", walk_a, 1'b1);
                32:       check("walk_ar", {red_a, walk_a}, 4'b1110);
                33:       check("post_walk_g1", green_a, 3'b010);
                default: ;
            endcase
        end

        // Skip to the only occupied direction; fixed rotation ignores sensors
        do_reset();
        tick(1, 0, 3'b111);
        for (int n = 2; n <= 8; n++) tick(1, 0, 3'b100);
        check("skip_a", green_a, 3'b100);
        check("skip_b", green_b, 3'b010);

        // No vehicles: fall back to successor
        do_reset();
        tick(1, 0, 3'b111);
        for (int n = 2; n <= 8; n++) tick(1, 0, 3'b000);
        check("fallback_a", green_a, 3'b010);
        check("fallback_b", green_b, 3'b010);

        // Enable freeze in the first yellow cycle
        do_reset();
        for (int n = 1; n <= 5; n++) tick(1, 0, 3'b111);
        check("frz_enter", yellow_a, 3'b001);
        repeat (5) begin
            tick(0, 0, 3'b111);
            check("frz_hold", yellow_a, 3'b001);
        end
        tick(1, 0, 3'b111);
        check("frz_y2", yellow_a, 3'b001);
        tick(1, 0, 3'b111);
        check("frz_ar", {red_a, yellow_a}, 6'b111000);
        tick(1, 0, 3'b111);
        check("frz_g1", green_a, 3'b010);

        // Request coincident with the walk grant
        do_reset();
        walk_cnt = 0;
        tick(1, 0, 3'b111);
        tick(1, 1, 3'b111);
        check("coin_pend", pend_a, 1'b1);
        for (int n = 3; n <= 12; n++) begin
            tick(1, n == 8, 3'b111);
            if (walk_a) walk_cnt++;
            if (n == 8)  check("coin_grant", {walk_a, pend_a}, 2'b10);
            if (n == 11) check("coin_after", {walk_a, pend_a}, 2'b00);
        end
        check("coin_walks", walk_cnt, 3);
        check("coin_g1", green_a, 3'b010);

        // Random sweep
        do_reset();
        repeat (2000) begin
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
